// File: rtl/leading_zero_normalizer_if.sv
// Handshake and data bundle for the post-adder normalizer.
// master drives the beat into the stage, slave is the normalizer.
interface leading_zero_normalizer_if #(
  parameter int SWR = 26,
  parameter int EW  = 8,
  parameter int LZW = 5
);
  logic           in_valid_i;
  logic           in_ready_o;
  logic [SWR-1:0] Sum_i;
  logic           C_i;
  logic [EW-1:0]  Exp_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [SWR-1:0] Norm_o;
  logic [EW-1:0]  Exp_o;
  logic [LZW-1:0] Lz_o;
  logic           Zero_o;
  logic           Ovf_o;
  logic           Unf_o;

  modport master (
    output in_valid_i, Sum_i, C_i, Exp_i, out_ready_i,
    input  in_ready_o, out_valid_o, Norm_o, Exp_o,
    input  Lz_o, Zero_o, Ovf_o, Unf_o
  );

  modport slave (
    input  in_valid_i, Sum_i, C_i, Exp_i, out_ready_i,
    output in_ready_o, out_valid_o, Norm_o, Exp_o,
    output Lz_o, Zero_o, Ovf_o, Unf_o
  );
endinterface

// File: rtl/leading_zero_normalizer.sv
// Two-stage post-adder normalizer: stage A counts leading zeros,
// stage B shifts the mantissa, adjusts the exponent and raises flags.
module leading_zero_normalizer #(
  parameter int SWR = 26,
  parameter int EW  = 8,
  parameter int LZW = 5
) (
  input logic clk,
  input logic rst,
  leading_zero_normalizer_if.slave bus
);
  localparam int CW = (EW > LZW) ? EW : LZW;

  logic           va;
  logic           vb;
  logic           adv_a;
  logic           adv_b;
  logic           acc;

  logic [SWR-1:0] sum_a;
  logic           c_a;
  logic [EW-1:0]  exp_a;
  logic [LZW-1:0] lz_a;
  logic [LZW-1:0] lz_in;

  logic [SWR-1:0] norm_n;
  logic [EW-1:0]  exp_n;
  logic [LZW-1:0] lz_n;
  logic           zero_n;
  logic           ovf_n;
  logic           unf_n;
  logic [CW-1:0]  ez;
  logic [CW-1:0]  lzz;

  logic [SWR-1:0] norm_q;
  logic [EW-1:0]  exp_q;
  logic [LZW-1:0] lz_q;
  logic           zero_q;
  logic           ovf_q;
  logic           unf_q;

  assign adv_b          = ~vb | bus.out_ready_i;
  assign adv_a          = va & adv_b;
  assign bus.in_ready_o = ~va | adv_b;
  assign acc            = bus.in_valid_i & bus.in_ready_o;

  // Leading-zero count of the incoming sum; highest set bit wins
  always_comb begin
    lz_in = LZW'(SWR);
    for (int i = 0; i < SWR; i++) begin
      if (bus.Sum_i[i]) lz_in = LZW'(SWR - 1 - i);
    end
  end

  // Stage A: capture the beat and its zero count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va    <= 1'b0;
      sum_a <= '0;
      c_a   <= 1'b0;
      exp_a <= '0;
      lz_a  <= '0;
    end else begin
      if (acc) begin
        va    <= 1'b1;
        sum_a <= bus.Sum_i;
        c_a   <= bus.C_i;
        exp_a <= bus.Exp_i;
        lz_a  <= lz_in;
      end else if (adv_a) begin
        va <= 1'b0;
      end
    end
  end

  // Normalize: carry shifts right, otherwise shift left by the count
  always_comb begin
    norm_n = '0;
    exp_n  = '0;
    lz_n   = '0;
    zero_n = 1'b0;
    ovf_n  = 1'b0;
    unf_n  = 1'b0;
    ez     = CW'(exp_a);
    lzz    = CW'(lz_a);
    unique case (1'b1)
      c_a: begin
        norm_n = {1'b1, sum_a[SWR-1:1]};
        if (exp_a == '1) begin
          ovf_n = 1'b1;
          exp_n = '1;
        end else begin
          exp_n = exp_a + EW'(1);
        end
      end
      (~c_a && sum_a == '0): begin
        zero_n = 1'b1;
      end
      default: begin
        norm_n = sum_a << lz_a;
        lz_n   = lz_a;
        if (lzz > ez) begin
          unf_n = 1'b1;
        end else begin
          exp_n = EW'(ez - lzz);
        end
      end
    endcase
  end

  // Stage B: output register, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vb     <= 1'b0;
      norm_q <= '0;
      exp_q  <= '0;
      lz_q   <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (adv_b) begin
      vb <= va;
      if (adv_a) begin
        norm_q <= norm_n;
        exp_q  <= exp_n;
        lz_q   <= lz_n;
        zero_q <= zero_n;
        ovf_q  <= ovf_n;
        unf_q  <= unf_n;
      end
    end
  end

  assign bus.out_valid_o = vb;
  assign bus.Norm_o      = norm_q;
  assign bus.Exp_o       = exp_q;
  assign bus.Lz_o        = lz_q;
  assign bus.Zero_o      = zero_q;
  assign bus.Ovf_o       = ovf_q;
  assign bus.Unf_o       = unf_q;
endmodule

// File: tb/tb_leading_zero_normalizer.sv
// Bench for the normalizer: directed table, handshake corners,
// random traffic against an arithmetic reference model.
module tb_leading_zero_normalizer;
  localparam int SWR = 26;
  localparam int EW  = 8;
  localparam int LZW = 5;

  typedef struct {
    logic [25:0] sum;
    logic        c;
    logic [7:0]  ex;
    logic [25:0] norm;
    logic [7:0]  expo;
    logic [4:0]  lz;
    logic        z;
    logic        o;
    logic        u;
  } vec_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   cyc;
  logic [63:0] exp_q[$];
  int   acc_log[$];
  int   out_log[$];
  bit   prev_stall;
  logic [63:0] prev_data;
  vec_t tbl[9];

  leading_zero_normalizer_if #(.SWR(SWR), .EW(EW), .LZW(LZW)) bus();

  leading_zero_normalizer #(.SWR(SWR), .EW(EW), .LZW(LZW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] outv();
    return {22'b0, bus.Norm_o, bus.Exp_o, bus.Lz_o,
            bus.Zero_o, bus.Ovf_o, bus.Unf_o};
  endfunction

  function automatic logic [63:0] pack(input vec_t v);
    return {22'b0, v.norm, v.expo, v.lz, v.z, v.o, v.u};
  endfunction

  function automatic logic [63:0] model(input logic [25:0] s,
                                        input logic c,
                                        input logic [7:0] e);
    logic [25:0] n;
    int ex;
    int lz;
    bit z;
    bit o;
    bit u;
    n = '0; ex = 0; lz = 0; z = 0; o = 0; u = 0;
    if (c) begin
      n  = s / 2 + 26'h2000000;
      ex = int'(e) + 1;
      if (ex > 255) begin
        ex = 255;
        o  = 1;
      end
    end else if (s == 0) begin
      z = 1;
    end else begin
      n = s;
      while (!n[25]) begin
        n = n << 1;
        lz++;
      end
      if (lz > int'(e)) u = 1;
      else ex = int'(e) - lz;
    end
    return {22'b0, n, 8'(ex), 5'(lz), z, o, u};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall)
        check("hold", {bus.out_valid_o, outv()}, {1'b1, prev_data});
      if (bus.in_valid_i && bus.in_ready_o) begin
        exp_q.push_back(model(bus.Sum_i, bus.C_i, bus.Exp_i));
        acc_log.push_back(cyc);
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        out_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("spurious_out", outv(), 64'hx);
        end else begin
          check("model", outv(), exp_q.pop_front());
        end
      end
      prev_stall = bus.out_valid_o && !bus.out_ready_i;
      prev_data  = outv();
    end
  end

  task automatic send(input logic [25:0] s, input logic c,
                      input logic [7:0] e);
    bit ok;
    ok = 0;
    bus.Sum_i      = s;
    bus.C_i        = c;
    bus.Exp_i      = e;
    bus.in_valid_i = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  initial begin
    bit got;
    int acc;
    cyc = 0;
    vectors = 0;
    miscompares = 0;
    prev_stall = 0;
    tbl[0] = '{26'h0000001, 0, 8'd100, 26'h2000000, 8'd75,  5'd25, 0, 0, 0};
    tbl[1] = '{26'h3FFFFFF, 1, 8'd100, 26'h3FFFFFF, 8'd101, 5'd0,  0, 0, 0};
    tbl[2] = '{26'h3FFFFFF, 1, 8'd255, 26'h3FFFFFF, 8'd255, 5'd0,  0, 1, 0};
    tbl[3] = '{26'h0000000, 0, 8'd50,  26'h0000000, 8'd0,   5'd0,  1, 0, 0};
    tbl[4] = '{26'h0000001, 0, 8'd10,  26'h2000000, 8'd0,   5'd25, 0, 0, 1};
    tbl[5] = '{26'h0123456, 0, 8'd20,  26'h2468AC0, 8'd15,  5'd5,  0, 0, 0};
    tbl[6] = '{26'h2000000, 0, 8'd0,   26'h2000000, 8'd0,   5'd0,  0, 0, 0};
    tbl[7] = '{26'h0000001, 0, 8'd25,  26'h2000000, 8'd0,   5'd25, 0, 0, 0};
    tbl[8] = '{26'h0000000, 1, 8'd7,   26'h2000000, 8'd8,   5'd0,  0, 0, 0};

    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.Sum_i       = '0;
    bus.C_i         = 1'b0;
    bus.Exp_i       = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_valid", 64'(bus.out_valid_o), 64'd0);
    check("reset_data", outv(), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(bus.in_ready_o), 64'd1);

    bus.out_ready_i = 1'b1;
    foreach (tbl[i]) begin
      send(tbl[i].sum, tbl[i].c, tbl[i].ex);
      got = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (bus.out_valid_o) begin
          got = 1;
          break;
        end
      end
      if (got) check($sformatf("table%0d", i), outv(), pack(tbl[i]));
      else check($sformatf("table%0d_timeout", i), 64'd0, 64'd1);
      @(posedge clk);
      #1;
    end

    // backpressure: 3 beats offered, only 2 fit
    bus.out_ready_i = 1'b0;
    acc = 0;
    bus.Sum_i = 26'h0000100;
    bus.C_i = 0;
    bus.Exp_i = 8'd40;
    bus.in_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.in_ready_o) acc++;
      @(posedge clk);
      #1;
      if (acc == 1) bus.Sum_i = 26'h0008000;
      if (acc == 2) bus.Sum_i = 26'h1000000;
    end
    check("bp_accepts", 64'(acc), 64'd2);
    @(negedge clk);
    check("bp_ready_low", 64'(bus.in_ready_o), 64'd0);
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b1;
    send(26'h1000000, 1'b0, 8'd40);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // back-to-back random stream
    acc_log.delete();
    out_log.delete();
    for (int i = 0; i < 16; i++)
      send(26'($urandom) >> $urandom_range(0, 25),
           1'($urandom_range(0, 3) == 0), 8'($urandom));
    for (int k = 0; k < 40 && out_log.size() < 16; k++) @(posedge clk);
    #1;
    check("b2b_outs", 64'(out_log.size()), 64'd16);
    check("b2b_accs", 64'(acc_log.size()), 64'd16);
    if (acc_log.size() == 16 && out_log.size() == 16) begin
      check("b2b_in_rate", 64'(acc_log[15] - acc_log[0]), 64'd15);
      check("b2b_latency", 64'(out_log[0] - acc_log[0]), 64'd2);
      check("b2b_out_rate", 64'(out_log[15] - out_log[0]), 64'd15);
    end

    // random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      bus.in_valid_i  = 1'($urandom_range(0, 1));
      bus.Sum_i       = 26'($urandom) >> $urandom_range(0, 26);
      bus.C_i         = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: bus.Exp_i = 8'd0;
        1: bus.Exp_i = 8'd255;
        default: bus.Exp_i = 8'($urandom);
      endcase
    end
    @(posedge clk);
    #1;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // async reset with two beats in flight
    bus.out_ready_i = 1'b0;
    send(26'h0000010, 1'b0, 8'd90);
    send(26'h0000020, 1'b0, 8'd90);
    check("flight_valid", 64'(bus.out_valid_o), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_valid", 64'(bus.out_valid_o), 64'd0);
    check("async_data", outv(), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale", 64'(bus.out_valid_o), 64'd0);
    end
    check("ready_post_rst", 64'(bus.in_ready_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
